// File: rtl/enemy_collision_pkg.sv
// enemy_collision_pkg
// Shared types and constants for the enemy collision detector.
//   - state_e           : enemy life-cycle states (ALIVE, HIT, DEAD)
//   - SCORE_W/SCORE_MAX : score register width and saturation ceiling
//   - *_DEF             : default values for the top-level parameters
//   - score_add()       : saturating score addition
package enemy_collision_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    DEAD  = 2'd2
  } state_e;

  localparam int SCORE_W = 14;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

  localparam int NUM_SHOTS_DEF      = 3;
  localparam int HIT_SCORE_DEF      = 10;
  localparam int BORDER_HOLDOFF_DEF = 4;
  localparam int HIT_POINTS_DEF     = 3;

  // Adds inc to cur, clamping at SCORE_MAX instead of wrapping.
  function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] cur,
                                                   input logic [SCORE_W-1:0] inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum > {1'b0, SCORE_MAX}) begin
      return SCORE_MAX;
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/enemy_collision_detector_frame_event_latch.sv
// frame_event_latch
// Sticky OR of an event vector over one video frame.
//   clk, reset : clock, asynchronous active-high reset
//   sof        : start-of-frame pulse; the accumulator restarts here
//   clr        : holds the accumulator at zero (enemy not alive / respawning)
//   in_vec     : per-pixel event bits
//   frame_o    : accumulated value of the frame ending at the next sof;
//                the consumer samples it on the sof cycle, so this is the
//                snapshot of the finished frame at that instant.
module frame_event_latch #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sof,
  input  logic         clr,
  input  logic [W-1:0] in_vec,
  output logic [W-1:0] frame_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  // Next accumulator value; on sof the current pixel starts the new frame.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (sof) begin
      acc_d = in_vec;
    end else begin
      acc_d = acc_q | in_vec;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign frame_o = acc_q;

endmodule

// File: rtl/enemy_collision_detector.sv
// enemy_collision_detector
// Per-enemy collision front end: accumulates enemy/shot and enemy/border
// pixel overlaps over a frame and, on the following start-of-frame, issues
// one-cycle kill / consume / change-direction pulses. Also tracks the
// enemy life-cycle (ALIVE -> HIT -> DEAD -> ALIVE on respawn) and a
// saturating kill score.
// Ports:
//   clk, reset             : pixel clock, asynchronous active-high reset
//   startOfFrame           : one-cycle frame start pulse
//   enemyDrawingRequest    : enemy covers the current pixel
//   shotDrawingRequest[i]  : shot i covers the current pixel
//   borderDrawingRequest   : border covers the current pixel
//   respawn                : level, reinitialises/revives the enemy
//   pause                  : level, suppresses event generation
//   shotCollision[i]       : kill pulse, shot i involved
//   changeDirection        : border bounce pulse
//   shotConsumed[i]        : shot i must disappear
//   enemyAlive             : high while in ALIVE
//   score                  : accumulated kill score (saturates at 9999)
// Optional build macro: ENEMY_COLLISION_MULTI_HIT_EN (enemy takes
// HIT_POINTS hits to kill; otherwise the first hit kills).
module enemy_collision_detector
  import enemy_collision_pkg::*;
#(
  parameter int NUM_SHOTS      = NUM_SHOTS_DEF,
  parameter int HIT_SCORE      = HIT_SCORE_DEF,
  parameter int BORDER_HOLDOFF = BORDER_HOLDOFF_DEF,
  parameter int HIT_POINTS     = HIT_POINTS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 enemyDrawingRequest,
  input  logic [NUM_SHOTS-1:0] shotDrawingRequest,
  input  logic                 borderDrawingRequest,
  input  logic                 respawn,
  input  logic                 pause,
  output logic [NUM_SHOTS-1:0] shotCollision,
  output logic                 changeDirection,
  output logic [NUM_SHOTS-1:0] shotConsumed,
  output logic                 enemyAlive,
  output logic [SCORE_W-1:0]   score
);

  localparam int HOLD_W = (BORDER_HOLDOFF > 0) ? $clog2(BORDER_HOLDOFF + 1) : 1;

  state_e               state_q, state_d;
  logic [NUM_SHOTS-1:0] shot_collision_q, shot_collision_d;
  logic [NUM_SHOTS-1:0] shot_consumed_q, shot_consumed_d;
  logic                 change_direction_q, change_direction_d;
  logic                 enemy_alive_q, enemy_alive_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [HOLD_W-1:0]    holdoff_q, holdoff_d;

  logic                 acc_clr;
  logic [NUM_SHOTS-1:0] hit_acc;
  logic [0:0]           border_acc;

`ifdef ENEMY_COLLISION_MULTI_HIT_EN
  localparam int CNT_W = (HIT_POINTS > 0) ? $clog2(HIT_POINTS + 1) : 1;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
`endif

  // Accumulation only runs while alive; respawn discards the frame so far.
  assign acc_clr = (state_q != ALIVE) | respawn;

  frame_event_latch #(.W(NUM_SHOTS)) u_hit_latch (
    .clk     (clk),
    .reset   (reset),
    .sof     (startOfFrame),
    .clr     (acc_clr),
    .in_vec  ({NUM_SHOTS{enemyDrawingRequest}} & shotDrawingRequest),
    .frame_o (hit_acc)
  );

  frame_event_latch #(.W(1)) u_border_latch (
    .clk     (clk),
    .reset   (reset),
    .sof     (startOfFrame),
    .clr     (acc_clr),
    .in_vec  (enemyDrawingRequest & borderDrawingRequest),
    .frame_o (border_acc)
  );

  // Next-state and registered-output logic, evaluated on the SOF cycle.
  always_comb begin
    state_d            = state_q;
    shot_collision_d   = '0;
    shot_consumed_d    = '0;
    change_direction_d = 1'b0;
    score_d            = score_q;
    holdoff_d          = holdoff_q;
`ifdef ENEMY_COLLISION_MULTI_HIT_EN
    hit_cnt_d          = hit_cnt_q;
`endif
    case (state_q)
      ALIVE: begin
        if (respawn) begin
          holdoff_d = '0;
`ifdef ENEMY_COLLISION_MULTI_HIT_EN
          hit_cnt_d = CNT_W'(HIT_POINTS);
`endif
        end else if (startOfFrame && !pause) begin
          if (|hit_acc) begin
            // A hit takes priority over the border bounce.
            shot_consumed_d = hit_acc;
`ifdef ENEMY_COLLISION_MULTI_HIT_EN
            if (hit_cnt_q <= CNT_W'(1)) begin
              hit_cnt_d        = '0;
              shot_collision_d = hit_acc;
              score_d          = score_add(score_q, SCORE_W'(HIT_SCORE));
              state_d          = HIT;
            end else begin
              hit_cnt_d = hit_cnt_q - CNT_W'(1);
            end
`else
            shot_collision_d = hit_acc;
            score_d          = score_add(score_q, SCORE_W'(HIT_SCORE));
            state_d          = HIT;
`endif
          end else if (border_acc[0] && (holdoff_q == '0)) begin
            change_direction_d = 1'b1;
            holdoff_d          = HOLD_W'(BORDER_HOLDOFF);
          end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HOLD_W'(1);
          end else begin
            holdoff_d = holdoff_q;
          end
        end else begin
          state_d = ALIVE;
        end
      end
      HIT: begin
        state_d = DEAD;
      end
      DEAD: begin
        if (respawn) begin
          state_d   = ALIVE;
          holdoff_d = '0;
`ifdef ENEMY_COLLISION_MULTI_HIT_EN
          hit_cnt_d = CNT_W'(HIT_POINTS);
`endif
        end else begin
          state_d = DEAD;
        end
      end
      default: begin
        state_d = ALIVE;
      end
    endcase
    enemy_alive_d = (state_d == ALIVE);
  end

  // State, output and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ALIVE;
      shot_collision_q   <= '0;
      shot_consumed_q    <= '0;
      change_direction_q <= 1'b0;
      enemy_alive_q      <= 1'b1;
      score_q            <= '0;
      holdoff_q          <= '0;
`ifdef ENEMY_COLLISION_MULTI_HIT_EN
      hit_cnt_q          <= CNT_W'(HIT_POINTS);
`endif
    end else begin
      state_q            <= state_d;
      shot_collision_q   <= shot_collision_d;
      shot_consumed_q    <= shot_consumed_d;
      change_direction_q <= change_direction_d;
      enemy_alive_q      <= enemy_alive_d;
      score_q            <= score_d;
      holdoff_q          <= holdoff_d;
`ifdef ENEMY_COLLISION_MULTI_HIT_EN
      hit_cnt_q          <= hit_cnt_d;
`endif
    end
  end

  assign shotCollision   = shot_collision_q;
  assign shotConsumed    = shot_consumed_q;
  assign changeDirection = change_direction_q;
  assign enemyAlive      = enemy_alive_q;
  assign score           = score_q;

endmodule
